ir_assembler: RTL

IR_ASSEMBLER -- requirements
Module: ir_assembler

---
 rtl/ir_pkg.sv | 19 +
 rtl/ir_assembler_if.sv | 35 +++
 rtl/ir_beat_ctr.sv | 102 ++++++++++
 rtl/ir_assembler.sv | 94 +++++++++
 4 files changed

// File: rtl/ir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_pkg
// Purpose  : Shared types and default sizing for the instruction assembler.
// Revision : 1.0 - initial release
// ============================================================================
package ir_pkg;

  // Assembler control state: waiting for a first beat, or collecting beats.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int DEF_BUS_W     = 8;
  localparam int DEF_MAX_BEATS = 4;

endpackage
`default_nettype wire

// File: rtl/ir_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : ir_assembler_if
// Purpose  : Beat input and assembled-instruction output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ir_assembler_if #(
  parameter int BUS_W     = ir_pkg::DEF_BUS_W,
  parameter int MAX_BEATS = ir_pkg::DEF_MAX_BEATS
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic                       ena;
  logic                       clr;
  logic [BUS_W-1:0]           data;
  logic [CW-1:0]              len;
  logic [BUS_W*MAX_BEATS-1:0] ir;
  logic                       ir_valid;
  logic                       busy;
  logic [CW-1:0]              beat_cnt;
  logic                       len_err;

  // Fetch side: supplies beats, observes the assembled result.
  modport master (
    output ena, clr, data, len,
    input  ir, ir_valid, busy, beat_cnt, len_err
  );

  // Assembler side.
  modport slave (
    input  ena, clr, data, len,
    output ir, ir_valid, busy, beat_cnt, len_err
  );
endinterface
`default_nettype wire

// File: rtl/ir_beat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : ir_beat_ctr
// Purpose  : IDLE/FILL sequencer, beat counter and length comparator. Tells
//            the assembler where to store each beat and when to commit.
// Revision : 1.0 - initial release
// ============================================================================
module ir_beat_ctr
  import ir_pkg::*;
#(
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          ena,
  input  wire logic          clr,
  input  wire logic [CW-1:0] len,
  output logic               busy,
  output logic [CW-1:0]      beat_cnt,
  output logic               len_err,
  output logic               capture,
  output logic [CW-1:0]      wr_idx,
  output logic               commit,
  output logic [CW-1:0]      len_eff
);

  state_t        state;
  logic [CW-1:0] len_q;
  logic          len_ok;

  assign len_ok = (len != '0) && (len <= CW'(MAX_BEATS));
  assign busy   = (state == FILL);

  // Decode this edge's action: store a beat, and whether it completes the
  // instruction. The first beat is judged against the live len, later beats
  // against the latched one.
  always_comb begin
    capture = 1'b0;
    commit  = 1'b0;
    wr_idx  = beat_cnt;
    len_eff = len_q;
    unique case (state)
      IDLE: begin
        if (ena && !clr && len_ok) begin
          capture = 1'b1;
          wr_idx  = '0;
          len_eff = len;
          commit  = (len == CW'(1));
        end
      end
      FILL: begin
        if (ena && !clr) begin
          capture = 1'b1;
          commit  = ((beat_cnt + CW'(1)) == len_q);
        end
      end
      default: ;
    endcase
  end

  // Sequencer: state, beat count, latched length and length-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ena && !clr) begin
            if (len_ok) begin
              len_q <= len;
              if (len == CW'(1)) begin
                beat_cnt <= '0;
              end else begin
                beat_cnt <= CW'(1);
                state    <= FILL;
              end
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        FILL: begin
          // clr or a gap in ena abandons the partial instruction.
          if (clr || !ena || commit) begin
            beat_cnt <= '0;
            state    <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ir_assembler.sv
`default_nettype none
// ============================================================================
// Module   : ir_assembler
// Purpose  : Collects 1..MAX_BEATS fetched beats into one right-aligned,
//            zero-extended instruction word.
// Revision : 1.0 - initial release
// ============================================================================
module ir_assembler
  import ir_pkg::*;
#(
  parameter int BUS_W      = DEF_BUS_W,
  parameter int MAX_BEATS  = DEF_MAX_BEATS,
  parameter int BIG_ENDIAN = 1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  ir_assembler_if.slave bus
);

  localparam int CW   = $clog2(MAX_BEATS + 1);
  localparam int IR_W = BUS_W * MAX_BEATS;

  logic             capture;
  logic             commit;
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    len_eff;
  logic [BUS_W-1:0] shadow     [MAX_BEATS];
  logic [BUS_W-1:0] shadow_nxt [MAX_BEATS];
  logic [IR_W-1:0]  ir_nxt;
  logic [IR_W-1:0]  ir_q;
  logic             ir_valid_q;

  ir_beat_ctr #(.MAX_BEATS(MAX_BEATS)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .ena      (bus.ena),
    .clr      (bus.clr),
    .len      (bus.len),
    .busy     (bus.busy),
    .beat_cnt (bus.beat_cnt),
    .len_err  (bus.len_err),
    .capture  (capture),
    .wr_idx   (wr_idx),
    .commit   (commit),
    .len_eff  (len_eff)
  );

  // Shadow contents including this edge's beat, so the final beat can be
  // committed on the same edge that captures it.
  always_comb begin
    for (int i = 0; i < MAX_BEATS; i++) begin
      shadow_nxt[i] = (capture && (wr_idx == CW'(i))) ? bus.data : shadow[i];
    end
  end

  // Place beats into the right-aligned word; slots at or above len stay zero
  // so stale beats from longer instructions never leak through.
  always_comb begin
    ir_nxt = '0;
    for (int p = 0; p < MAX_BEATS; p++) begin
      for (int i = 0; i < MAX_BEATS; i++) begin
        if (p < int'(len_eff)) begin
          if ((BIG_ENDIAN != 0) ? (i + p + 1 == int'(len_eff)) : (i == p)) begin
            ir_nxt[p*BUS_W +: BUS_W] = shadow_nxt[i];
          end
        end
      end
    end
  end

  // Shadow buffer, committed instruction and its valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_BEATS; i++) begin
        shadow[i] <= '0;
      end
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_BEATS; i++) begin
        shadow[i] <= shadow_nxt[i];
      end
      ir_valid_q <= commit;
      if (commit) begin
        ir_q <= ir_nxt;
      end
    end
  end

  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;

endmodule
`default_nettype wire
